// File: rtl/regfile_dump_reader.sv
// Sequential dump of a register range through the register file's third read port.
// Each register is captured and presented as one word on a valid/ready stream.
module regfile_dump_reader #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              btn,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] first_reg,
    input  logic [ADDR_W-1:0] last_reg,
    output logic [ADDR_W-1:0] regC,
    input  logic [DATA_W-1:0] Cdat,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_idx,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_OUT,
        S_DONE
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_cur;
    logic [ADDR_W-1:0]   r_end;
    logic [ADDR_W-1:0]   r_regc;
    logic [DATA_W-1:0]   r_data;
    logic [ADDR_W-1:0]   r_idx;
    logic                r_last;
    logic                r_valid;
    logic                w_accept;
    logic                w_at_end;

    assign w_accept = r_valid & out_ready;
    assign w_at_end = (r_cur == r_end);

    // NOTE: every variable assigned in always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (start) w_next = S_READ;
            S_READ: w_next = abort ? S_IDLE : S_OUT;
            S_OUT: begin
                if (abort)         w_next = S_IDLE;
                else if (w_accept) w_next = w_at_end ? S_DONE : S_READ;
            end
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from the pre-edge values.
    always_ff @(negedge btn or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Datapath follows the FSM; abort wins over acceptance in OUT.
    always_ff @(negedge btn or posedge rst) begin
        if (rst) begin
            r_cur   <= '0;
            r_end   <= '0;
            r_regc  <= '0;
            r_data  <= '0;
            r_idx   <= '0;
            r_last  <= 1'b0;
            r_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cur  <= first_reg;
                        r_end  <= last_reg;
                        r_regc <= first_reg;
                    end
                end
                S_READ: begin
                    if (!abort) begin
                        r_data  <= Cdat;
                        r_idx   <= r_cur;
                        r_last  <= w_at_end;
                        r_valid <= 1'b1;
                    end
                end
                S_OUT: begin
                    if (abort) begin
                        r_valid <= 1'b0;
                    end else if (w_accept) begin
                        r_valid <= 1'b0;
                        if (!w_at_end) begin
                            r_cur  <= r_cur + 1'b1;
                            r_regc <= r_cur + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign regC      = r_regc;
    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_idx   = r_idx;
    assign out_last  = r_last;
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_DONE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Scoreboard bench for regfile_dump_reader: expected words are queued from a
// register-file model at start and compared as the DUT presents them.
module tb_regfile_dump_reader;

    logic        btn = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [4:0]  first_reg;
    logic [4:0]  last_reg;
    logic [4:0]  regC;
    logic [31:0] Cdat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [4:0]  out_idx;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] mem [32];

    typedef struct packed {
        logic [4:0]  idx;
        logic [31:0] data;
        logic        last;
    } word_t;

    word_t exp_q[$];

    int checks;
    int failures;
    int cyc;
    int done_cnt;
    int acc_cnt;
    int last_acc_cyc;

    regfile_dump_reader #(.DATA_W(32), .ADDR_W(5)) dut (
        .btn       (btn),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .first_reg (first_reg),
        .last_reg  (last_reg),
        .regC      (regC),
        .Cdat      (Cdat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 btn = ~btn;

    // Register-file read port: index 0 always reads as zero.
    assign Cdat = (regC == 5'd0) ? 32'd0 : mem[regC];

    function automatic logic [31:0] rd(input logic [4:0] i);
        return (i == 5'd0) ? 32'd0 : mem[i];
    endfunction

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic push_range(input logic [4:0] f, input logic [4:0] l);
        int n;
        logic [4:0] i;
        word_t w;
        n = int'(5'(l - f)) + 1;
        for (int k = 0; k < n; k++) begin
            i      = 5'(f + 5'(k));
            w.idx  = i;
            w.data = rd(i);
            w.last = (k == n - 1);
            exp_q.push_back(w);
        end
    endtask

    // Called right after a posedge with inputs already driven for the coming negedge.
    task automatic tick();
        #1;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("spurious_word_qsize", exp_q.size(), 1);
            end else begin
                check("out_idx",  out_idx,  exp_q[0].idx);
                check("out_data", out_data, exp_q[0].data);
                check("out_last", out_last, exp_q[0].last);
                if (out_ready && !abort) begin
                    void'(exp_q.pop_front());
                    acc_cnt++;
                    last_acc_cyc = cyc;
                end
            end
        end
        if (done) begin
            done_cnt++;
            check("done_after_accept", cyc, last_acc_cyc + 1);
        end
        @(posedge btn);
        cyc++;
    endtask

    task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int stall,
                            input int abort_idx, input bit restart);
        int d0;
        int a0;
        int c0;
        int stall_left;
        bit aborted;
        bit seen_valid;
        d0 = done_cnt;
        a0 = acc_cnt;
        stall_left = stall;
        aborted = 1'b0;
        seen_valid = 1'b0;
        push_range(f, l);
        start = 1'b1;
        first_reg = f;
        last_reg = l;
        out_ready = 1'b1;
        c0 = cyc;
        tick();
        start = 1'b0;
        first_reg = 5'($urandom);
        last_reg = 5'($urandom);
        for (int b = 0; b < 200 && done_cnt == d0 && !aborted; b++) begin
            start = restart && (b == 2);
            if (start) begin
                first_reg = 5'd20;
                last_reg = 5'd25;
            end
            out_ready = 1'b1;
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
            end
            abort = out_valid && (abort_idx >= 0) && (out_idx == abort_idx[4:0]);
            if (out_valid && !seen_valid) begin
                seen_valid = 1'b1;
                check("first_valid_latency", cyc, c0 + 2);
            end
            tick();
            if (abort) begin
                aborted = 1'b1;
                abort = 1'b0;
                exp_q.delete();
            end
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (aborted) begin
            check("abort_valid_low", out_valid, 0);
            check("abort_busy_low", busy, 0);
            check("abort_words_before", acc_cnt - a0, 5'(abort_idx[4:0] - f));
            repeat (4) tick();
            check("abort_no_done", done_cnt - d0, 0);
        end else begin
            check("done_pulses", done_cnt - d0, 1);
            check("words_left", exp_q.size(), 0);
            check("idle_busy_low", busy, 0);
            check("idle_valid_low", out_valid, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        done_cnt = 0;
        acc_cnt = 0;
        last_acc_cyc = -10;
        for (int i = 0; i < 32; i++) mem[i] = 32'h1000 + 32'(i) * 32'h35;
        rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        first_reg = 5'd0;
        last_reg = 5'd0;
        #2 rst = 1'b1;
        repeat (2) @(posedge btn);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_regC", regC, 0);
        check("rst_data", out_data, 0);
        check("rst_idx", out_idx, 0);
        check("rst_last", out_last, 0);
        rst = 1'b0;
        @(posedge btn);

        // Simple range
        mem[1] = 32'd11; mem[2] = 32'd22; mem[3] = 32'd33;
        run_dump(5'd1, 5'd3, 0, -1, 1'b0);

        // Wrap through index 31 to 0
        mem[30] = 32'hA; mem[31] = 32'hB; mem[1] = 32'hC; mem[0] = 32'hDEAD;
        run_dump(5'd30, 5'd1, 0, -1, 1'b0);

        // Single word with consumer stalled for 4 cycles
        run_dump(5'd5, 5'd5, 4, -1, 1'b0);

        // Abort while word index 2 is offered with ready high
        run_dump(5'd0, 5'd7, 0, 2, 1'b0);

        // Asynchronous reset between edges mid-dump
        push_range(5'd0, 5'd7);
        start = 1'b1; first_reg = 5'd0; last_reg = 5'd7; out_ready = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_regC", regC, 0);
        check("midrst_done", done, 0);
        rst = 1'b0;
        exp_q.delete();
        out_ready = 1'b0;
        @(posedge btn);
        cyc++;
        mem[4] = 32'h4444_0004;
        run_dump(5'd4, 5'd4, 0, -1, 1'b0);

        // start re-pulsed while busy with a different range
        run_dump(5'd10, 5'd12, 1, -1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
